sha256_compression_core: RTL and testbench
==========================================

// Module: sha256_compression_core
// PURPOSE
//  Downstream consumer of the message expansion stage: takes one schedule word W_t per cycle
//  and runs the 64 SHA-256 compression rounds on working vars a..h.
//  Adds the result into the chaining hash H0..H7 and presents the 256-bit digest.
//  Shares start with the expansion stage, so round t's word arrives in lockstep with round_in==t.
// PARAMETERS
//  CHECK_ROUND  1  1: compare round_in with internal round counter, abort on mismatch; 0: no check
// PORTS
//  CLK        in   1    clock
//  RST        in   1    reset, asynchronous, active-low
//  start_in   in   1    same pulse driving expansion start; sampled only in IDLE
//  init_in    in   1    with start_in: 1 = seed from SHA-256 IV (first block), 0 = chain from current H
//  w_in       in   32   schedule word W_t from the expansion stage
//  round_in   in   7    round index t from the expansion stage
//  exp_state_in in 2    expansion FSM state (0 = IDLE); nonzero means w_in/round_in valid
//  hash_out   out  256  {H0,H1,...,H7}, H0 in bits [255:224]
//  busy_out   out  1    1 while state != IDLE
//  done_out   out  1    one-cycle pulse: hash_out updated with this block
//  err_out    out  1    sticky; set on round mismatch or early drop of exp_state_in, cleared by next start
// BEHAVIOUR
//  Reset (async, RST=0): state=IDLE; H0..H7 = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a
//   510e527f 9b05688c 1f83d9ab 5be0cd19); a..h=0; rnd=0; busy/done/err=0.
//  FSM: IDLE -> RUN -> ADD -> IDLE.
//  IDLE:
//   - start_in=1: a..h <= init_in ? IV : H; rnd<=0; err<=0; ->RUN.
//   - init_in=1 also loads H<=IV on the same edge.
//  RUN: each edge with exp_state_in!=0 executes one round using K[rnd] and w_in:
//   - T1 = h + S1(e) + Ch(e,f,g) + K[rnd] + w_in
//   - T2 = S0(a) + Maj(a,b,c)
//   - h<=g; g<=f; f<=e; e<=d+T1; d<=c; c<=b; b<=a; a<=T1+T2
//   - rnd<=rnd+1; when rnd==63 ->ADD.
//   - S1 = ROTR6^ROTR11^ROTR25; S0 = ROTR2^ROTR13^ROTR22; all adds mod 2^32.
//   - K: 64-entry constant ROM (standard SHA-256 K, 428a2f98..c67178f2), indexed by internal rnd.
//  ADD: Hi <= Hi + {a..h}[i] mod 2^32; ->IDLE. done_out=1 in the cycle after the ADD edge.
//  Latency: start edge at cycle 0, rounds on cycles 1..64, H add on 65, done_out high on cycle 66.
//   - start_in may be re-asserted in that same cycle (IDLE) for back-to-back blocks.
//  Error:
//   - CHECK_ROUND=1 and round_in!=rnd in RUN -> err<=1, ->IDLE; H unchanged, no done_out.
//   - exp_state_in==0 in RUN -> err<=1, ->IDLE (check independent of CHECK_ROUND).
//  start_in outside IDLE ignored (no restart, no effect on H).
//  init_in ignored unless sampled with start_in in IDLE.
//  Reset mid-RUN: immediate return to reset values; partial block discarded; H = IV.
//  busy_out = (state!=IDLE), combinational from state register.
// TESTING
//  T1 "abc" single padded block, init_in=1 -> done_out on cycle 66,
//     hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
//  T2 empty-message block (80000000, 0...0) -> e3b0c442 98fc1c14 9afbf4c8 996fb924
//     27ae41e4 649b934c a495991b 7852b855.
//  T3 two-block "abcdbcdecdefdefg...nopq": block1 init_in=1, block2 init_in=0, back-to-back
//     -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  T4 force round_in=5 when rnd=4 -> err_out=1 next cycle, busy_out=0, no done_out, H unchanged.
//     Next start clears err_out.
//  T5 RST low at round 30 -> all outputs at reset values immediately, hash_out=IV.
//     Rerun of T1 still correct.
//  T6 start_in pulsed at round 10 -> ignored; T1 digest unchanged, done_out exactly once.

Source files
------------

// File: rtl/sha256_compression_core.sv
`default_nettype none
// ============================================================================
// Module   : sha256_compression_core
// Purpose  : Runs the 64 SHA-256 compression rounds on schedule words that
//            arrive one per cycle from the expansion stage, then folds the
//            working variables into the chaining hash H0..H7.
// Revision : 1.0  initial release
// ============================================================================
module sha256_compression_core #(
  parameter int CHECK_ROUND = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start_in,
  input  logic         init_in,
  input  logic [31:0]  w_in,
  input  logic [6:0]   round_in,
  input  logic [1:0]   exp_state_in,
  output logic [255:0] hash_out,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_ADD  = 2'd2
  } state_t;

  localparam logic [255:0] c_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Ascending packed range so that c_K[0] is the first listed constant.
  localparam logic [0:63][31:0] c_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t            state_q, state_d;
  logic [7:0][31:0]  hv_q, hv_d;   // [7] = H0 ... [0] = H7, matches hash_out layout
  logic [7:0][31:0]  wv_q, wv_d;   // [7] = a  ... [0] = h
  logic [5:0]        rnd_q, rnd_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [31:0]       sig0, sig1, ch, maj, t1, t2;
  logic [7:0][31:0]  round_nxt;
  logic              round_bad;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One compression round on the current working variables.
  always_comb begin
    sig1      = rotr(wv_q[3], 6) ^ rotr(wv_q[3], 11) ^ rotr(wv_q[3], 25);
    ch        = (wv_q[3] & wv_q[2]) ^ (~wv_q[3] & wv_q[1]);
    t1        = wv_q[0] + sig1 + ch + c_K[rnd_q] + w_in;
    sig0      = rotr(wv_q[7], 2) ^ rotr(wv_q[7], 13) ^ rotr(wv_q[7], 22);
    maj       = (wv_q[7] & wv_q[6]) ^ (wv_q[7] & wv_q[5]) ^ (wv_q[6] & wv_q[5]);
    t2        = sig0 + maj;
    round_nxt = {t1 + t2, wv_q[7], wv_q[6], wv_q[5], wv_q[4] + t1, wv_q[3], wv_q[2], wv_q[1]};
    round_bad = (CHECK_ROUND != 0) && (round_in != {1'b0, rnd_q});
  end

  // Next-state and datapath control for IDLE -> RUN -> ADD -> IDLE.
  always_comb begin
    state_d = state_q;
    hv_d    = hv_q;
    wv_d    = wv_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          wv_d    = init_in ? c_IV : hv_q;
          if (init_in) hv_d = c_IV;
          rnd_d   = 6'd0;
          err_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // An absent or out-of-step word aborts the block; H keeps its old value.
        if ((exp_state_in == 2'd0) || round_bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wv_d  = round_nxt;
          rnd_d = rnd_q + 6'd1;
          if (rnd_q == 6'd63) state_d = S_ADD;
        end
      end
      S_ADD: begin
        for (int i = 0; i < 8; i++) hv_d[i] = hv_q[i] + wv_q[i];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset restores the IV and discards any partial block.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      hv_q    <= c_IV;
      wv_q    <= '0;
      rnd_q   <= 6'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hv_q    <= hv_d;
      wv_q    <= wv_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign hash_out = hv_q;
  assign busy_out = (state_q != S_IDLE);
  assign done_out = done_q;
  assign err_out  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_compression_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_compression_core
// Purpose  : Scoreboard bench for sha256_compression_core. The bench plays the
//            expansion stage and predicts digests with a reference SHA-256.
// Revision : 1.0  initial release
// ============================================================================
module tb_sha256_compression_core;

  localparam int M_OK     = 0;
  localparam int M_BADRND = 1;
  localparam int M_DROP   = 2;
  localparam int M_RST    = 3;
  localparam int M_SPUR   = 4;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'd0, 32'h00000000, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'd0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [511:0] BLK_TWO2  = {480'd0, 32'h000001c0};

  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  typedef logic [63:0][31:0] wsched_t;

  logic         CLK = 1'b0;
  logic         RST;
  logic         start_in, init_in;
  logic [31:0]  w_in;
  logic [6:0]   round_in;
  logic [1:0]   exp_state_in;
  logic [255:0] hash_out;
  logic         busy_out, done_out, err_out;

  int           total = 0;
  int           bad   = 0;
  logic [255:0] sb[$];
  logic [255:0] model_h;

  always #5 CLK = ~CLK;

  sha256_compression_core #(.CHECK_ROUND(1)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .start_in     (start_in),
    .init_in      (init_in),
    .w_in         (w_in),
    .round_in     (round_in),
    .exp_state_in (exp_state_in),
    .hash_out     (hash_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  // ---------------- reference SHA-256 ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic wsched_t sched(input logic [511:0] blk);
    wsched_t w;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    return w;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    wsched_t      w;
    logic [31:0]  v [8];
    logic [31:0]  x1, x2;
    logic [255:0] hout;
    w = sched(blk);
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return hout;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST === 1'b1 && done_out === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_out=1 expected no pending block");
      end else begin
        chk("digest", hash_out, sb.pop_front());
      end
    end
  end

  // Plays the expansion stage for one block, starting #1 after a rising edge.
  task automatic drive_block(input logic [511:0] blk, input bit init, input int mode,
                             input int at, input logic [255:0] expd);
    wsched_t ws;
    ws           = sched(blk);
    start_in     = 1'b1;
    init_in      = init;
    exp_state_in = 2'd0;
    @(posedge CLK); #1;
    start_in = 1'b0;
    init_in  = 1'b0;
    chk("busy_after_start", {255'd0, busy_out}, 256'd1);
    chk("err_after_start", {255'd0, err_out}, 256'd0);
    if (mode == M_OK || mode == M_SPUR) sb.push_back(expd);
    for (int t = 0; t < 64; t++) begin
      w_in         = ws[t];
      round_in     = 7'(t);
      exp_state_in = 2'd1;
      if (t == at) begin
        case (mode)
          M_BADRND: round_in = 7'(t + 1);
          M_DROP:   exp_state_in = 2'd0;
          M_SPUR:   begin start_in = 1'b1; init_in = ~init; end
          M_RST: begin
            RST = 1'b0;
            #1;
            chk("rst_hash", hash_out, IV);
            chk("rst_busy", {255'd0, busy_out}, 256'd0);
            chk("rst_done", {255'd0, done_out}, 256'd0);
            chk("rst_err", {255'd0, err_out}, 256'd0);
            #1;
            RST          = 1'b1;
            exp_state_in = 2'd0;
            model_h      = IV;
            @(posedge CLK); #1;
            return;
          end
          default: ;
        endcase
      end
      @(posedge CLK); #1;
      start_in = 1'b0;
      init_in  = 1'b0;
      if (t == at && (mode == M_BADRND || mode == M_DROP)) begin
        chk("err_set", {255'd0, err_out}, 256'd1);
        chk("err_busy", {255'd0, busy_out}, 256'd0);
        chk("err_hash_kept", hash_out, model_h);
        exp_state_in = 2'd0;
        repeat (3) @(posedge CLK);
        #1;
        chk("err_sticky", {255'd0, err_out}, 256'd1);
        return;
      end
    end
    exp_state_in = 2'd0;
    chk("done_before_add", {255'd0, done_out}, 256'd0);
    chk("busy_in_add", {255'd0, busy_out}, 256'd1);
    @(posedge CLK); #1;
    chk("done_latency", {255'd0, done_out}, 256'd1);
    chk("busy_after_add", {255'd0, busy_out}, 256'd0);
    model_h = expd;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  // Stimulus sequence.
  initial begin
    logic [511:0] blk;
    logic [255:0] e;
    bit           ini;
    RST = 1'b0; start_in = 1'b0; init_in = 1'b0;
    w_in = '0; round_in = '0; exp_state_in = '0;
    model_h = IV;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_hash", hash_out, IV);
    chk("reset_busy", {255'd0, busy_out}, 256'd0);
    chk("reset_done", {255'd0, done_out}, 256'd0);
    chk("reset_err", {255'd0, err_out}, 256'd0);
    RST = 1'b1;
    @(posedge CLK); #1;

    drive_block(BLK_ABC, 1'b1, M_OK, -1, DIG_ABC);
    repeat (2) @(posedge CLK);
    #1;
    drive_block(BLK_EMPTY, 1'b1, M_OK, -1, DIG_EMPTY);

    // Two-block message, back-to-back starts.
    drive_block(BLK_TWO1, 1'b1, M_OK, -1, compress(IV, BLK_TWO1));
    drive_block(BLK_TWO2, 1'b0, M_OK, -1, DIG_TWO);

    // Round mismatch, then a clean block clears the error.
    drive_block(BLK_ABC, 1'b0, M_BADRND, 4, '0);
    drive_block(BLK_EMPTY, 1'b0, M_OK, -1, compress(model_h, BLK_EMPTY));

    // Expansion stage drops out mid-block.
    drive_block(BLK_ABC, 1'b0, M_DROP, 20, '0);

    // Reset in the middle of a block, then the same block again.
    drive_block(BLK_ABC, 1'b1, M_RST, 30, '0);
    drive_block(BLK_ABC, 1'b1, M_OK, -1, DIG_ABC);

    // Spurious start during RUN must be ignored.
    drive_block(BLK_ABC, 1'b1, M_SPUR, 10, DIG_ABC);

    // Random blocks, randomly chained, sometimes back-to-back.
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 16; j++) blk[32*j +: 32] = $urandom;
      ini = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      e   = compress(ini ? IV : model_h, blk);
      drive_block(blk, ini, M_OK, -1, e);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        #1;
      end
    end

    repeat (3) @(posedge CLK);
    #1;
    chk("scoreboard_empty", 256'(sb.size()), 256'd0);
    chk("final_hash", hash_out, model_h);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
